// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// Each operation is accepted in IDLE, executed in EXEC and held in RESP until the owner consumes it.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req0_shamt,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  input  logic             req1_shamt,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             op_shamt;
  logic             owner;
  logic             rr_ptr;    // requester favoured when both are valid

  logic             grant_any;
  logic             grant_idx;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [2:0]       pick_sel;
  logic             pick_shamt;
  logic             rsp_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_any  = req0_valid | req1_valid;
    grant_idx  = 1'b0;
    pick_a     = req0_a;
    pick_b     = req0_b;
    pick_sel   = req0_sel;
    pick_shamt = req0_shamt;

    if (req0_valid && req1_valid) begin
      grant_idx = rr_ptr;
    end else begin
      grant_idx = req1_valid;
    end

    if (grant_idx) begin
      pick_a     = req1_a;
      pick_b     = req1_b;
      pick_sel   = req1_sel;
      pick_shamt = req1_shamt;
    end

    // Ready is masked during reset so no handshake is ever visible while the block is being cleared.
    req0_ready = (state == IDLE) && !rst && req0_valid && !grant_idx;
    req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_idx;
  end

  // The non-owner's consume signal is deliberately not looked at.
  assign rsp_done  = owner ? rsp1_ready : rsp0_ready;

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_sel   = op_sel;
  assign alu_shamt = op_shamt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      op_shamt   <= 1'b0;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            op_a     <= pick_a;
            op_b     <= pick_b;
            op_sel   <= pick_sel;
            op_shamt <= pick_shamt;
            owner    <= grant_idx;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end

        EXEC: begin
          rsp_data   <= alu_result;
          rsp_carry  <= alu_carry;
          rsp0_valid <= ~owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end

        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= ~owner;
            state      <= IDLE;
          end
        end

        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level reference model predicts every
// output each cycle, around directed scenarios and a randomized soak with sporadic resets.
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_sel, req1_sel;
  logic             req0_shamt, req1_shamt;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_sel;
  logic             alu_shamt, alu_carry;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             busy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_shamt(req1_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy)
  );

  // Shared ALU behaviour; returns {carry, result}.
  function automatic logic [16:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [2:0] sel, logic sh);
    logic [16:0] r;
    case (sel)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {a[0], a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = sh ? {a[15], a[14:0], 1'b0} : {1'b0, a};
      3'd6:    r = sh ? {a[0], 1'b0, a[15:1]} : {1'b0, a};
      default: r = {b[15], ~a};
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel, alu_shamt);

  // Reference model: one in-flight transaction record plus the identity of the last requester served.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic        sh;
  } op_t;

  op_t         m_op;
  bit          m_busy;
  int          m_owner;
  int          m_age;     // cycles since the accepting edge
  int          m_last;    // last requester whose response completed
  logic [15:0] m_data;
  logic        m_carry;

  int cyc;
  int grant_cyc[$];
  int grant_who[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int winner();
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    return req1_valid ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_age   = 0;
    m_last  = 1;
    m_data  = '0;
    m_carry = 1'b0;
    m_op    = '{a: '0, b: '0, sel: '0, sh: 1'b0};
  endtask

  // One clock: compare all outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic e_r0, e_r1, e_v0, e_v1;
    @(negedge clk);
    if (rst) begin
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_ready1", req1_ready, 1'b0);
    end else begin
      e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          if (winner() == 0) e_r0 = 1'b1;
          else               e_r1 = 1'b1;
        end
      end else if (m_age >= 2) begin
        e_v0 = (m_owner == 0);
        e_v1 = (m_owner == 1);
      end
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("rsp0_valid", rsp0_valid, e_v0);
      check("rsp1_valid", rsp1_valid, e_v1);
      check("busy",       busy,       m_busy);
      check("rsp_data",   rsp_data,   m_data);
      check("rsp_carry",  rsp_carry,  m_carry);
      check("alu_a",      alu_a,      m_op.a);
      check("alu_b",      alu_b,      m_op.b);
      check("alu_sel",    alu_sel,    m_op.sel);
      check("alu_shamt",  alu_shamt,  m_op.sh);
    end

    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_owner = winner();
        if (m_owner == 1) m_op = '{a: req1_a, b: req1_b, sel: req1_sel, sh: req1_shamt};
        else              m_op = '{a: req0_a, b: req0_b, sel: req0_sel, sh: req0_shamt};
        m_busy = 1'b1;
        m_age  = 1;
        grant_cyc.push_back(cyc);
        grant_who.push_back(m_owner);
      end
    end else if (m_age == 1) begin
      {m_carry, m_data} = alu_fn(m_op.a, m_op.b, m_op.sel, m_op.sh);
      m_age = 2;
    end else if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
    #1;
  endtask

  task automatic drive0(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel, input logic sh);
    req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; req0_shamt = sh;
  endtask

  task automatic drive1(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel, input logic sh);
    req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; req1_shamt = sh;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    drive0(1'b0, '0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy",   busy,       1'b0);
    check("post_rst_valid0", rsp0_valid, 1'b0);
    check("post_rst_valid1", rsp1_valid, 1'b0);
    check("post_rst_data",   rsp_data,   16'h0000);

    // Single ADD from req0.
    drive0(1'b1, 16'h0003, 16'h0004, 3'd0, 1'b0);
    #1;
    check("add_ready0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    check("add_exec_valid0", rsp0_valid, 1'b0);
    step();
    check("add_valid0", rsp0_valid, 1'b1);
    check("add_valid1", rsp1_valid, 1'b0);
    check("add_data",   rsp_data,   16'h0007);
    check("add_carry",  rsp_carry,  1'b0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Carry out of a 16-bit add from req1.
    drive1(1'b1, 16'hFFFF, 16'h0001, 3'd0, 1'b0);
    step();
    req1_valid = 1'b0;
    step();
    check("carry_valid1", rsp1_valid, 1'b1);
    check("carry_valid0", rsp0_valid, 1'b0);
    check("carry_data",   rsp_data,   16'h0000);
    check("carry_flag",   rsp_carry,  1'b1);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // Backpressure on req0 while req1 waits.
    drive0(1'b1, 16'h1234, 16'h0101, 3'd0, 1'b0);
    step();
    req0_valid = 1'b0;
    drive1(1'b1, 16'h00F0, 16'h0F00, 3'd3, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid0", rsp0_valid, 1'b1);
      check("bp_data",   rsp_data,   16'h1335);
      check("bp_busy",   busy,       1'b1);
      check("bp_ready1", req1_ready, 1'b0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("bp_release_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    check("bp_alu_a", alu_a, 16'h00F0);
    step();
    check("bp_valid1", rsp1_valid, 1'b1);
    check("bp_data1",  rsp_data,   16'h0FF0);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // Reset while an operation is in EXEC.
    drive0(1'b1, 16'h0005, 16'h0006, 3'd0, 1'b0);
    drive1(1'b1, 16'h0009, 16'h0001, 3'd1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid0", rsp0_valid, 1'b0);
    check("midrst_valid1", rsp1_valid, 1'b0);
    check("midrst_data",   rsp_data,   16'h0000);
    check("midrst_busy",   busy,       1'b0);
    check("midrst_ready0", req0_ready, 1'b1);
    check("midrst_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    step();
    step();
    rsp0_ready = 1'b0;

    // Fairness: both requesters valid continuously from reset, consumers always ready.
    rst = 1'b1;
    step();
    rst = 1'b0;
    grant_cyc.delete();
    grant_who.delete();
    drive0(1'b1, 16'h1111, 16'h2222, 3'd4, 1'b0);
    drive1(1'b1, 16'h8001, 16'h0003, 3'd5, 1'b1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 13; i++) step();
    check("fair_count", grant_who.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < grant_who.size(); i++) begin
      check("fair_owner", grant_who[i], i % 2);
      if (i > 0) check("fair_interval", grant_cyc[i] - grant_cyc[i-1], 3);
    end

    // Randomized soak with sporadic resets.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      rsp0_ready = ($urandom_range(0, 99) < 60);
      rsp1_ready = ($urandom_range(0, 99) < 60);
      drive0($urandom_range(0, 99) < 55, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
      drive1($urandom_range(0, 99) < 55, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
